rpn_calc_ctrl: RTL and testbench
================================

Name: rpn_calc_ctrl

Overview:
Clocked, parametrised RPN calculator controller. Accepts 4-bit key codes over a valid/ready handshake, keeps a DEPTH-entry signed operand stack, performs add/subtract with signed-overflow detection, and stores/loads operands to an external register file over a request/response interface. Sits between the keypad decoder and the register file / display logic.

Parameters:
WIDTH, 8, operand width in bits, two's complement
DEPTH, 4, operand stack entries (min 2); entry 0 = X, entry 1 = Y
NREGS, 10, number of addressable external registers
AW, 4, register address width; NREGS <= 2**AW
LOAD_TIMEOUT, 15, max cycles waiting for reg_rvalid before error

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
key_valid  in  1  key_code is valid
key_code  in  4  0-9 digit, A add, B sub, C store, D load, E enter, F clear-error/nop
key_ready  out  1  controller can accept a key this cycle
x_out  out  WIDTH  stack entry 0 (X)
y_out  out  WIDTH  stack entry 1 (Y)
err  out  1  sticky error flag
reg_addr  out  AW  register file address
reg_wdata  out  WIDTH  register write data
reg_we  out  1  one-cycle write strobe
reg_re  out  1  one-cycle read request
reg_rvalid  in  1  read data valid
reg_rdata  in  WIDTH  read data

Behaviour:
- Reset (async, reset=0): all stack entries 0, state IDLE, err=0, reg_we=0, reg_re=0, reg_addr=0, reg_wdata=0, internal flags entering=0 and lift=0; key_ready=1 once reset deasserts.
- States: IDLE, LOAD_WAIT, ERR. key_ready=1 in IDLE and ERR, 0 in LOAD_WAIT.
- Key accepted on the rising edge where key_valid & key_ready. Results are visible the next cycle (latency 1), except load.
- Digit d: if entering=1, X <= X*10+d; else if lift=1, push (entry[i] <= entry[i-1], top entry discarded) then X <= d; else X <= d. Sets entering=1, lift=0. If X*10+d exceeds the signed max, the operation is an overflow.
- E: push; X is duplicated into Y. Sets entering=0, lift=0.
- A / B: result Y+X / Y-X computed at WIDTH bits. Result goes to X; entries 2..DEPTH-1 shift down; the top entry is filled with 0. Signed overflow is detected from operand and result sign bits. Sets entering=0, lift=1.
- C: if X<0 or X>=NREGS, the operation is an error. Otherwise reg_we=1 for one cycle, reg_addr=X[AW-1:0], reg_wdata=Y. Stack unchanged. Sets entering=0, lift=1.
- D: range check as for C. If in range, reg_re=1 for one cycle, reg_addr=X, state becomes LOAD_WAIT. On reg_rvalid: X <= reg_rdata, state becomes IDLE, entering=0, lift=1. If reg_rvalid has not arrived after LOAD_TIMEOUT cycles, the operation is an error. A reg_rvalid received outside LOAD_WAIT is ignored.
- F in IDLE: no operation.
- Overflow/error: X <= signed max (e.g. 127), other entries unchanged, err=1, state ERR, reg_we=0.
- ERR state: only F is acted on. F clears err, sets state IDLE, entering=0, lift=1. All other keys are accepted and discarded.
- reg_addr holds its last value between accesses. reg_we and reg_re are never asserted together.
- Reset mid-load: immediate return to reset state; any late reg_rvalid is ignored.

Decomposition:
- Package rpn_calc_pkg holds: key-code localparams (KEY_ADD=4'hA ... KEY_CLR=4'hF), state enum, and a signed-max constant function of WIDTH.
- Sub-module rpn_stack (parameters WIDTH, DEPTH) implements push, pop-with-replace, replace-X and clear, and exposes X and Y.
- The controller FSM, the arithmetic, and the overflow checks live in rpn_calc_ctrl.

Test Plan:
- Reset (defaults): release reset -> x_out=0, y_out=0, err=0, key_ready=1, reg_we=0, reg_re=0.
- Add (defaults): keys 1,2,E,3,0,A -> X=42, Y=0; after 4,A -> X=46.
- Overflow and clear (defaults): keys 1,0,0,E,5,0,A -> err=1, X=127. Then key 5 -> X stays 127. Then key F -> err=0, X=127, key_ready=1.
- Subtract to negative (defaults): keys 5,E,9,B -> X=8'hFC (-4), no error.
- Store then load (defaults): keys 7,E,3,C -> one-cycle reg_we, reg_addr=3, reg_wdata=7. Then keys 3,D with the model returning 7 two cycles later -> reg_re for one cycle, key_ready=0 while waiting, X=7.
- Range and timeout errors (defaults): keys 1,2,C -> err=1, no reg_we. Separately, keys 2,D with no reg_rvalid -> err=1 after 15 cycles. Reset asserted during LOAD_WAIT -> stack 0, a late reg_rvalid is ignored.

Source files
------------

// File: rtl/rpn_calc_pkg.sv
// Shared definitions for the RPN calculator controller.
// Key codes, FSM states, stack ops and the signed-max helper.
package rpn_calc_pkg;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_STO = 4'hC;
    localparam logic [3:0] KEY_RCL = 4'hD;
    localparam logic [3:0] KEY_ENT = 4'hE;
    localparam logic [3:0] KEY_CLR = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_WAIT,
        ERR
    } state_t;

    typedef enum logic [2:0] {
        STK_NOP,
        STK_PUSH,
        STK_POP,
        STK_SETX,
        STK_CLEAR
    } stk_op_t;

    function automatic int signed_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

endpackage

// File: rtl/rpn_stack.sv
// Operand stack: push, pop-with-replace, replace-X and clear.
// Entry 0 is X, entry 1 is Y.
module rpn_stack
    import rpn_calc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  stk_op_t          op,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] ent [DEPTH];

    // stack entries update according to the requested op
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
        end else begin
            unique case (op)
                STK_PUSH: begin
                    ent[0] <= din;
                    for (int i = 1; i < DEPTH; i++) ent[i] <= ent[i-1];
                end
                STK_POP: begin
                    ent[0] <= din;
                    for (int i = 1; i < DEPTH - 1; i++) ent[i] <= ent[i+1];
                    ent[DEPTH-1] <= '0;
                end
                STK_SETX: ent[0] <= din;
                STK_CLEAR: begin
                    for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
                end
                default: ;
            endcase
        end
    end

    assign x = ent[0];
    assign y = ent[1];

endmodule

// File: rtl/rpn_calc_ctrl.sv
// RPN calculator controller: key decode, add/sub, store/load.
// Any overflow or range/timeout error saturates X and parks in ERR.
module rpn_calc_ctrl
    import rpn_calc_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 4,
    parameter int NREGS        = 10,
    parameter int AW           = 4,
    parameter int LOAD_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    output logic             key_ready,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic             err,
    output logic [AW-1:0]    reg_addr,
    output logic [WIDTH-1:0] reg_wdata,
    output logic             reg_we,
    output logic             reg_re,
    input  logic             reg_rvalid,
    input  logic [WIDTH-1:0] reg_rdata
);

    localparam logic [WIDTH-1:0] SMAX = WIDTH'(signed_max(WIDTH));
    localparam int TW = $clog2(LOAD_TIMEOUT + 1);
    localparam int M  = WIDTH - 1;

    state_t           state, state_n;
    logic             entering, entering_n;
    logic             lift, lift_n;
    logic             err_n, fault;
    logic [TW-1:0]    tcnt, tcnt_n;
    logic [AW-1:0]    addr_n;
    logic [WIDTH-1:0] wdata_n;
    logic             we_n, re_n;
    stk_op_t          sop;
    logic [WIDTH-1:0] sdin;

    logic             accept, is_digit;
    logic [WIDTH+4:0] xs, dk, dig_ext;
    logic [5:0]       dig_hi;
    logic             dig_ov;
    logic [WIDTH-1:0] sum, diff;
    logic             add_ov, sub_ov, oor;

    rpn_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
        .clk  (clk),
        .reset(reset),
        .op   (sop),
        .din  (sdin),
        .x    (x_out),
        .y    (y_out)
    );

    assign key_ready = (state != LOAD_WAIT);
    assign accept    = key_valid & key_ready;
    assign is_digit  = (key_code <= 4'd9);

    // digit entry evaluated wide; it fits only if the top bits agree
    assign xs      = {{5{x_out[M]}}, x_out};
    assign dk      = {(WIDTH + 1)'(0), key_code};
    assign dig_ext = (entering ? (xs << 3) + (xs << 1) : '0) + dk;
    assign dig_hi  = dig_ext[WIDTH+4:WIDTH-1];
    assign dig_ov  = !((&dig_hi) || (~|dig_hi));

    assign sum    = y_out + x_out;
    assign diff   = y_out - x_out;
    assign add_ov = (x_out[M] == y_out[M]) && (sum[M] != y_out[M]);
    assign sub_ov = (x_out[M] != y_out[M]) && (diff[M] != y_out[M]);
    assign oor    = x_out[M] || ({1'b0, x_out} >= (WIDTH + 1)'(NREGS));

    // next-state, stack op and register-port decode
    always_comb begin
        state_n    = state;
        entering_n = entering;
        lift_n     = lift;
        err_n      = err;
        tcnt_n     = tcnt;
        addr_n     = reg_addr;
        wdata_n    = reg_wdata;
        we_n       = 1'b0;
        re_n       = 1'b0;
        sop        = STK_NOP;
        sdin       = x_out;
        fault      = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    unique case (1'b1)
                        is_digit: begin
                            if (dig_ov) begin
                                fault = 1'b1;
                            end else begin
                                sdin       = dig_ext[WIDTH-1:0];
                                sop        = (!entering && lift) ? STK_PUSH : STK_SETX;
                                entering_n = 1'b1;
                                lift_n     = 1'b0;
                            end
                        end
                        (key_code == KEY_ADD): begin
                            if (add_ov) fault = 1'b1;
                            else begin
                                sop        = STK_POP;
                                sdin       = sum;
                                entering_n = 1'b0;
                                lift_n     = 1'b1;
                            end
                        end
                        (key_code == KEY_SUB): begin
                            if (sub_ov) fault = 1'b1;
                            else begin
                                sop        = STK_POP;
                                sdin       = diff;
                                entering_n = 1'b0;
                                lift_n     = 1'b1;
                            end
                        end
                        (key_code == KEY_STO): begin
                            if (oor) fault = 1'b1;
                            else begin
                                we_n       = 1'b1;
                                addr_n     = x_out[AW-1:0];
                                wdata_n    = y_out;
                                entering_n = 1'b0;
                                lift_n     = 1'b1;
                            end
                        end
                        (key_code == KEY_RCL): begin
                            if (oor) fault = 1'b1;
                            else begin
                                re_n    = 1'b1;
                                addr_n  = x_out[AW-1:0];
                                tcnt_n  = '0;
                                state_n = LOAD_WAIT;
                            end
                        end
                        (key_code == KEY_ENT): begin
                            sop        = STK_PUSH;
                            sdin       = x_out;
                            entering_n = 1'b0;
                            lift_n     = 1'b0;
                        end
                        (key_code == KEY_CLR): ;
                    endcase
                end
            end
            LOAD_WAIT: begin
                if (reg_rvalid) begin
                    sop        = STK_SETX;
                    sdin       = reg_rdata;
                    state_n    = IDLE;
                    entering_n = 1'b0;
                    lift_n     = 1'b1;
                end else if (tcnt == TW'(LOAD_TIMEOUT - 1)) begin
                    fault = 1'b1;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            ERR: begin
                if (accept && key_code == KEY_CLR) begin
                    err_n      = 1'b0;
                    state_n    = IDLE;
                    entering_n = 1'b0;
                    lift_n     = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (fault) begin
            sop     = STK_SETX;
            sdin    = SMAX;
            err_n   = 1'b1;
            state_n = ERR;
            we_n    = 1'b0;
            re_n    = 1'b0;
        end
    end

    // state, flags and registered register-port outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            entering  <= 1'b0;
            lift      <= 1'b0;
            err       <= 1'b0;
            tcnt      <= '0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
        end else begin
            state     <= state_n;
            entering  <= entering_n;
            lift      <= lift_n;
            err       <= err_n;
            tcnt      <= tcnt_n;
            reg_addr  <= addr_n;
            reg_wdata <= wdata_n;
            reg_we    <= we_n;
            reg_re    <= re_n;
        end
    end

endmodule

// File: tb/tb_rpn_calc_ctrl.sv
// Self-checking bench for rpn_calc_ctrl.
// Table-driven key vectors plus hand sequences for store/load.
module tb_rpn_calc_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       key_ready;
    logic [7:0] x_out, y_out;
    logic       err;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we, reg_re;
    logic       reg_rvalid = 1'b0;
    logic [7:0] reg_rdata = 8'h00;

    rpn_calc_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready),
        .x_out     (x_out),
        .y_out     (y_out),
        .err       (err),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rvalid(reg_rvalid),
        .reg_rdata (reg_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] key;
        logic [7:0] x;
        logic [7:0] y;
        logic       e;
    } vec_t;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    wr_t  wr_q[$];
    wr_t  mw;
    vec_t ev;
    int   checks = 0;
    int   errors = 0;
    int   writes = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void kv(input logic [3:0] k, input logic [7:0] x,
                               input logic [7:0] y, input logic e);
        tbl.push_back('{1'b0, k, x, y, e});
    endfunction

    function automatic void rv();
        tbl.push_back('{1'b1, 4'h0, 8'h00, 8'h00, 1'b0});
    endfunction

    task automatic do_reset();
        key_valid  = 1'b0;
        reg_rvalid = 1'b0;
        reset      = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic send(input logic [3:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // register-file side monitor: every write must be expected
    always @(negedge clk) begin
        if (reset) begin
            if (reg_we && reg_re) begin
                checks++;
                errors++;
                $display("FAIL we_re_both: got 1 expected 0");
            end
            if (reg_we) begin
                writes++;
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0h data %0h", reg_addr, reg_wdata);
                end else begin
                    mw = wr_q.pop_front();
                    check("wr_addr", int'(reg_addr), int'(mw.addr));
                    check("wr_data", int'(reg_wdata), int'(mw.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rv();
        kv(4'h1, 8'd1, 8'd0, 0);   kv(4'h2, 8'd12, 8'd0, 0);
        kv(4'hE, 8'd12, 8'd12, 0); kv(4'h3, 8'd3, 8'd12, 0);
        kv(4'h0, 8'd30, 8'd12, 0); kv(4'hA, 8'd42, 8'd0, 0);
        kv(4'h4, 8'd4, 8'd42, 0);  kv(4'hA, 8'd46, 8'd0, 0);
        rv();
        kv(4'h1, 8'd1, 8'd0, 0);     kv(4'h0, 8'd10, 8'd0, 0);
        kv(4'h0, 8'd100, 8'd0, 0);   kv(4'hE, 8'd100, 8'd100, 0);
        kv(4'h5, 8'd5, 8'd100, 0);   kv(4'h0, 8'd50, 8'd100, 0);
        kv(4'hA, 8'd127, 8'd100, 1); kv(4'h5, 8'd127, 8'd100, 1);
        kv(4'hF, 8'd127, 8'd100, 0);
        rv();
        kv(4'h5, 8'd5, 8'd0, 0); kv(4'hE, 8'd5, 8'd5, 0);
        kv(4'h9, 8'd9, 8'd5, 0); kv(4'hB, 8'hFC, 8'd0, 0);
        rv();
        kv(4'h1, 8'd1, 8'd0, 0); kv(4'h2, 8'd12, 8'd0, 0);
        kv(4'hC, 8'd127, 8'd0, 1);

        foreach (tbl[i]) begin
            if (tbl[i].rst) begin
                do_reset();
                check($sformatf("v%0d rst_x", i), int'(x_out), 0);
                check($sformatf("v%0d rst_y", i), int'(y_out), 0);
                check($sformatf("v%0d rst_err", i), int'(err), 0);
                check($sformatf("v%0d rst_rdy", i), int'(key_ready), 1);
                check($sformatf("v%0d rst_we", i), int'(reg_we), 0);
                check($sformatf("v%0d rst_re", i), int'(reg_re), 0);
            end else begin
                exp_q.push_back(tbl[i]);
                send(tbl[i].key);
                ev = exp_q.pop_front();
                check($sformatf("v%0d x", i), int'(x_out), int'(ev.x));
                check($sformatf("v%0d y", i), int'(y_out), int'(ev.y));
                check($sformatf("v%0d err", i), int'(err), int'(ev.e));
                check($sformatf("v%0d rdy", i), int'(key_ready), 1);
            end
        end
        check("range_no_write", writes, 0);

        // store Y=7 to register 3, then load it back
        do_reset();
        send(4'h7);
        send(4'hE);
        send(4'h3);
        wr_q.push_back('{4'd3, 8'd7});
        send(4'hC);
        check("sto_we", int'(reg_we), 1);
        check("sto_addr", int'(reg_addr), 3);
        check("sto_wdata", int'(reg_wdata), 7);
        check("sto_re", int'(reg_re), 0);
        tick();
        check("sto_we_drop", int'(reg_we), 0);
        check("sto_writes", writes, 1);
        send(4'h3);
        check("pre_ld_x", int'(x_out), 3);
        check("pre_ld_y", int'(y_out), 3);
        send(4'hD);
        check("ld_re", int'(reg_re), 1);
        check("ld_addr", int'(reg_addr), 3);
        check("ld_rdy", int'(key_ready), 0);
        check("ld_we", int'(reg_we), 0);
        tick();
        check("ld_re_drop", int'(reg_re), 0);
        check("ld_rdy_wait", int'(key_ready), 0);
        @(negedge clk);
        reg_rvalid = 1'b1;
        reg_rdata  = 8'd7;
        key_valid  = 1'b1;
        key_code   = 4'h5;
        tick();
        reg_rvalid = 1'b0;
        key_valid  = 1'b0;
        check("ld_x", int'(x_out), 7);
        check("ld_y", int'(y_out), 3);
        check("ld_rdy_back", int'(key_ready), 1);
        check("ld_err", int'(err), 0);

        // load timeout
        do_reset();
        send(4'h2);
        send(4'hD);
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (c == 14) check("tmo_err_early", int'(err), 0);
            if (c == 15) begin
                check("tmo_err", int'(err), 1);
                check("tmo_x", int'(x_out), 127);
                check("tmo_rdy", int'(key_ready), 1);
            end
        end

        // reset in the middle of a load
        do_reset();
        send(4'h4);
        send(4'hD);
        tick();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_x", int'(x_out), 0);
        check("mid_rst_rdy", int'(key_ready), 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reg_rvalid = 1'b1;
        reg_rdata  = 8'h55;
        tick();
        reg_rvalid = 1'b0;
        check("late_rv_x", int'(x_out), 0);
        check("late_rv_rdy", int'(key_ready), 1);
        check("late_rv_err", int'(err), 0);
        check("wr_q_empty", wr_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
